mul_iter_d: RTL

Iterative radix-4 unsigned multiplier for the Dilithium datapath. It sits directly upstream of the Barrett reduction stage. It accepts two coefficients through a valid/ready handshake and computes their full-width product, 2 multiplier bits per clock. It presents the 46-bit product on a valid/ready output, and that product is the reduction stage's input. Operands are normally already reduced mod 8380417. The block does not check this; any nb_bit-wide unsigned values are multiplied exactly.

---
 rtl/mul_iter_d.sv | 138 +++++++++++++
 1 files changed

// File: rtl/mul_iter_d.sv
// mul_iter_d: iterative radix-4 unsigned multiplier feeding Barrett reduction.
// Retires two multiplier bits per clock; full 2*nb_bit product on valid/ready.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        async reset, active-high
//   in_valid_i   operand pair valid
//   in_ready_o   pair can be accepted (combinational)
//   a_i, b_i     unsigned operands, nb_bit wide
//   out_valid_o  product_o holds a finished product
//   out_ready_i  downstream takes the product
//   product_o    a*b, exact, 2*nb_bit wide
//   busy_o       digits are being accumulated
module mul_iter_d #(
  parameter int nb_bit = 23
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [nb_bit-1:0]     a_i,
  input  logic [nb_bit-1:0]     b_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [2*nb_bit-1:0]   product_o,
  output logic                  busy_o
);

  localparam int PW = 2 * nb_bit;
  localparam int N  = (nb_bit + 1) / 2;
  localparam int BW = 2 * N;
  localparam int AW = nb_bit + 2;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t            state;
  logic [nb_bit-1:0] a_reg;
  logic [BW-1:0]     b_reg;
  logic [PW-1:0]     acc;
  logic [CW-1:0]     cnt;

  logic [1:0]        digit;
  logic [AW-1:0]     partial;
  logic [CW:0]       shamt;
  logic [PW-1:0]     term;
  logic [PW-1:0]     acc_nxt;
  logic              last;
  logic              accept;

  // Ready path from out_ready_i is deliberately combinational so a
  // consumed product and a new pair can share one edge.
  assign in_ready_o = (state == IDLE) ||
                      ((state == DONE) && out_ready_i);
  assign accept     = in_valid_i && in_ready_o;

  assign digit = b_reg[1:0];

  // digit * a as shift-and-add: 0, a, 2a, 3a
  always_comb begin
    partial = '0;
    unique case (digit)
      2'd0: partial = '0;
      2'd1: partial = AW'(a_reg);
      2'd2: partial = {1'b0, a_reg, 1'b0};
      2'd3: partial = AW'(a_reg) + {1'b0, a_reg, 1'b0};
      default: partial = '0;
    endcase
  end

  // Weight of digit cnt is 4^cnt; the full sum never exceeds PW bits.
  assign shamt   = {cnt, 1'b0};
  assign term    = PW'(partial) << shamt;
  assign acc_nxt = acc + term;
  assign last    = (cnt == CW'(N - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      a_reg       <= '0;
      b_reg       <= '0;
      acc         <= '0;
      cnt         <= '0;
      product_o   <= '0;
      out_valid_o <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            a_reg  <= a_i;
            b_reg  <= BW'(b_i);
            acc    <= '0;
            cnt    <= '0;
            busy_o <= 1'b1;
            state  <= BUSY;
          end
        end
        BUSY: begin
          acc   <= acc_nxt;
          b_reg <= b_reg >> 2;
          cnt   <= cnt + CW'(1);
          if (last) begin
            product_o   <= acc_nxt;
            out_valid_o <= 1'b1;
            busy_o      <= 1'b0;
            state       <= DONE;
          end
        end
        DONE: begin
          if (out_ready_i) begin
            out_valid_o <= 1'b0;
            if (in_valid_i) begin
              a_reg  <= a_i;
              b_reg  <= BW'(b_i);
              acc    <= '0;
              cnt    <= '0;
              busy_o <= 1'b1;
              state  <= BUSY;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state       <= IDLE;
          out_valid_o <= 1'b0;
          busy_o      <= 1'b0;
        end
      endcase
    end
  end

endmodule
